// File: rtl/uart_txrx_param.sv
//==============================================================================
// Module   : uart_txrx_param
// Purpose  : Full-duplex UART with configurable width, parity, stop bits and
//            an RX path with start-bit glitch rejection and error flags.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module uart_txrx_param #(
    parameter int M            = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_Tx_DV,
    input  logic [M-1:0] i_Tx_b,
    input  logic         i_Rx_serial,
    output logic         o_Tx_serial,
    output logic         o_Tx_active,
    output logic         o_data_sent,
    output logic         o_ready,
    output logic [M-1:0] o_Rx_b,
    output logic         o_Rx_DV,
    output logic         o_parity_err,
    output logic         o_frame_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = 4;
    localparam logic [CW-1:0] C_BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] C_HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IW-1:0] C_M_LAST    = IW'(M - 1);
    localparam logic [IW-1:0] C_STOP_LAST = IW'(STOP_BITS - 1);
    localparam logic          C_PAR_EN    = (PARITY != 0);
    localparam logic          C_PAR_ODD   = (PARITY == 2);

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH
    } rx_state_t;

    // ---------------------------------------------------------------- TX
    tx_state_t     tx_state_q, tx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [IW-1:0] tx_idx_q, tx_idx_d;
    logic [M-1:0]  tx_data_q, tx_data_d;
    logic          tx_par_q, tx_par_d;
    logic          tx_ser_q, tx_ser_d;
    logic          tx_sent_q, tx_sent_d;
    logic          w_tx_bit_end, w_tx_ready, w_tx_accept;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_idx_q   <= '0;
            tx_data_q  <= '0;
            tx_par_q   <= 1'b0;
            tx_ser_q   <= 1'b1;
            tx_sent_q  <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_idx_q   <= tx_idx_d;
            tx_data_q  <= tx_data_d;
            tx_par_q   <= tx_par_d;
            tx_ser_q   <= tx_ser_d;
            tx_sent_q  <= tx_sent_d;
        end
    end

    assign w_tx_bit_end = (tx_cnt_q == C_BIT_LAST);
    // Ready also on the final stop cycle so a held request starts the next
    // frame without an idle gap.
    assign w_tx_ready   = (tx_state_q == TX_IDLE) ||
                          (tx_state_q == TX_STOP && w_tx_bit_end && tx_idx_q == C_STOP_LAST);
    assign w_tx_accept  = i_Tx_DV && w_tx_ready;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_idx_d   = tx_idx_q;
        tx_data_d  = tx_data_q;
        tx_par_d   = tx_par_q;
        tx_ser_d   = tx_ser_q;
        tx_sent_d  = 1'b0;
        if (tx_state_q != TX_IDLE)
            tx_cnt_d = w_tx_bit_end ? '0 : tx_cnt_q + CW'(1);
        case (tx_state_q)
            TX_START: if (w_tx_bit_end) begin
                tx_state_d = TX_DATA;
                tx_idx_d   = '0;
                tx_ser_d   = tx_data_q[0];
            end
            TX_DATA: if (w_tx_bit_end) begin
                if (tx_idx_q == C_M_LAST) begin
                    tx_idx_d = '0;
                    if (C_PAR_EN) begin
                        tx_state_d = TX_PARITY;
                        tx_ser_d   = tx_par_q;
                    end else begin
                        tx_state_d = TX_STOP;
                        tx_ser_d   = 1'b1;
                    end
                end else begin
                    tx_idx_d  = tx_idx_q + IW'(1);
                    tx_ser_d  = tx_data_q[1];
                    tx_data_d = {1'b0, tx_data_q[M-1:1]};
                end
            end
            TX_PARITY: if (w_tx_bit_end) begin
                tx_state_d = TX_STOP;
                tx_idx_d   = '0;
                tx_ser_d   = 1'b1;
            end
            TX_STOP: if (w_tx_bit_end) begin
                if (tx_idx_q == C_STOP_LAST) begin
                    tx_state_d = TX_IDLE;
                    tx_sent_d  = 1'b1;
                end else begin
                    tx_idx_d = tx_idx_q + IW'(1);
                end
            end
            default: ;
        endcase
        if (w_tx_accept) begin
            tx_state_d = TX_START;
            tx_cnt_d   = '0;
            tx_data_d  = i_Tx_b;
            tx_par_d   = (^i_Tx_b) ^ C_PAR_ODD;
            tx_ser_d   = 1'b0;
        end
    end

    assign o_Tx_serial = tx_ser_q;
    assign o_Tx_active = (tx_state_q != TX_IDLE);
    assign o_data_sent = tx_sent_q;
    assign o_ready     = w_tx_ready;

    // ---------------------------------------------------------------- RX
    rx_state_t     rx_state_q, rx_state_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [IW-1:0] rx_idx_q, rx_idx_d;
    logic [M-1:0]  rx_shift_q, rx_shift_d;
    logic          rx_par_q, rx_par_d;
    logic [M-1:0]  rx_b_q, rx_b_d;
    logic          rx_dv_q, rx_dv_d;
    logic          rx_perr_q, rx_perr_d;
    logic          rx_ferr_q, rx_ferr_d;
    logic          rx_sync1_q, rx_sync2_q;
    logic          w_rx_bit, w_rx_bit_end;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            rx_sync1_q <= 1'b1;
            rx_sync2_q <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_idx_q   <= '0;
            rx_shift_q <= '0;
            rx_par_q   <= 1'b0;
            rx_b_q     <= '0;
            rx_dv_q    <= 1'b0;
            rx_perr_q  <= 1'b0;
            rx_ferr_q  <= 1'b0;
        end else begin
            rx_sync1_q <= i_Rx_serial;
            rx_sync2_q <= rx_sync1_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_idx_q   <= rx_idx_d;
            rx_shift_q <= rx_shift_d;
            rx_par_q   <= rx_par_d;
            rx_b_q     <= rx_b_d;
            rx_dv_q    <= rx_dv_d;
            rx_perr_q  <= rx_perr_d;
            rx_ferr_q  <= rx_ferr_d;
        end
    end

    assign w_rx_bit     = rx_sync2_q;
    assign w_rx_bit_end = (rx_cnt_q == C_BIT_LAST);

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + CW'(1);
        rx_idx_d   = rx_idx_q;
        rx_shift_d = rx_shift_q;
        rx_par_d   = rx_par_q;
        rx_b_d     = rx_b_q;
        rx_dv_d    = 1'b0;
        rx_perr_d  = rx_perr_q;
        rx_ferr_d  = rx_ferr_q;
        case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = '0;
                if (!w_rx_bit) rx_state_d = RX_START;
            end
            // Mid-start re-sample: a line already back high was a glitch.
            RX_START: if (rx_cnt_q == C_HALF_LAST) begin
                rx_cnt_d   = '0;
                rx_idx_d   = '0;
                rx_state_d = w_rx_bit ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (w_rx_bit_end) begin
                rx_cnt_d   = '0;
                rx_shift_d = {w_rx_bit, rx_shift_q[M-1:1]};
                if (rx_idx_q == C_M_LAST)
                    rx_state_d = C_PAR_EN ? RX_PARITY : RX_STOP;
                else
                    rx_idx_d = rx_idx_q + IW'(1);
            end
            RX_PARITY: if (w_rx_bit_end) begin
                rx_cnt_d   = '0;
                rx_par_d   = w_rx_bit;
                rx_state_d = RX_STOP;
            end
            RX_STOP: if (w_rx_bit_end) begin
                rx_cnt_d   = '0;
                rx_b_d     = rx_shift_q;
                rx_dv_d    = 1'b1;
                rx_ferr_d  = !w_rx_bit;
                rx_perr_d  = C_PAR_EN && ((^rx_shift_q) ^ rx_par_q ^ C_PAR_ODD);
                rx_state_d = w_rx_bit ? RX_IDLE : RX_WAIT_HIGH;
            end
            RX_WAIT_HIGH: begin
                rx_cnt_d = '0;
                if (w_rx_bit) rx_state_d = RX_IDLE;
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    assign o_Rx_b       = rx_b_q;
    assign o_Rx_DV      = rx_dv_q;
    assign o_parity_err = rx_perr_q;
    assign o_frame_err  = rx_ferr_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_txrx_param.sv
//==============================================================================
// Module   : tb_uart_txrx_param
// Purpose  : Randomised self-checking bench with a frame-level UART model.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_uart_txrx_param;

    localparam int M   = 8;
    localparam int CPB = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         dv      [2];
    logic [M-1:0] txb     [2];
    logic         loop_en [2];
    logic         drv     [2];
    logic         rx_in   [2];
    logic         tx_ser  [2];
    logic         tx_act  [2];
    logic         sent    [2];
    logic         rdy     [2];
    logic [M-1:0] rx_b    [2];
    logic         rx_dv   [2];
    logic         perr    [2];
    logic         ferr    [2];

    assign rx_in[0] = loop_en[0] ? tx_ser[0] : drv[0];
    assign rx_in[1] = loop_en[1] ? tx_ser[1] : drv[1];

    uart_txrx_param #(.M(M), .CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(1)) u_dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_Tx_DV(dv[0]), .i_Tx_b(txb[0]),
        .i_Rx_serial(rx_in[0]), .o_Tx_serial(tx_ser[0]), .o_Tx_active(tx_act[0]),
        .o_data_sent(sent[0]), .o_ready(rdy[0]), .o_Rx_b(rx_b[0]), .o_Rx_DV(rx_dv[0]),
        .o_parity_err(perr[0]), .o_frame_err(ferr[0])
    );

    uart_txrx_param #(.M(M), .CLKS_PER_BIT(CPB), .PARITY(1), .STOP_BITS(2)) u_dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_Tx_DV(dv[1]), .i_Tx_b(txb[1]),
        .i_Rx_serial(rx_in[1]), .o_Tx_serial(tx_ser[1]), .o_Tx_active(tx_act[1]),
        .o_data_sent(sent[1]), .o_ready(rdy[1]), .o_Rx_b(rx_b[1]), .o_Rx_DV(rx_dv[1]),
        .o_parity_err(perr[1]), .o_frame_err(ferr[1])
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Receive-side scoreboard: every o_Rx_DV with its flags and cycle stamp.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [M+1:0] rxq0[$], rxq1[$];
    int           rxt0[$], rxt1[$];
    int           sent_cnt0 = 0, sent_cnt1 = 0;

    always @(negedge clk) begin
        if (rx_dv[0]) begin rxq0.push_back({perr[0], ferr[0], rx_b[0]}); rxt0.push_back(cyc); end
        if (rx_dv[1]) begin rxq1.push_back({perr[1], ferr[1], rx_b[1]}); rxt1.push_back(cyc); end
        if (sent[0]) sent_cnt0++;
        if (sent[1]) sent_cnt1++;
    end

    // Frame model: bit list built straight from the frame-format rules.
    bit fr [0:15];
    int fr_len;

    task automatic build_frame(input logic [M-1:0] d, input int par, input int stops);
        int n;
        fr[0] = 1'b0;
        for (int i = 0; i < M; i++) fr[1+i] = d[i];
        n = 1 + M;
        if (par != 0) begin
            fr[n] = (($countones(d) % 2) == 1) ^ (par == 2);
            n++;
        end
        for (int s = 0; s < stops; s++) fr[n+s] = 1'b1;
        fr_len = n + stops;
    endtask

    function automatic int par_of(input int sel);
        return (sel == 0) ? 0 : 1;
    endfunction

    function automatic int stop_of(input int sel);
        return (sel == 0) ? 1 : 2;
    endfunction

    task automatic rx_clear();
        rxq0.delete(); rxq1.delete(); rxt0.delete(); rxt1.delete();
    endtask

    task automatic rx_expect(input int sel, input int n, input logic [M-1:0] d,
                             input logic pe, input logic fe);
        logic [M+1:0] e;
        int sz;
        sz = (sel == 0) ? rxq0.size() : rxq1.size();
        check_eq("rx_count", sz, n);
        for (int i = 0; i < sz && i < n; i++) begin
            if (sel == 0) begin e = rxq0.pop_front(); void'(rxt0.pop_front()); end
            else          begin e = rxq1.pop_front(); void'(rxt1.pop_front()); end
            check_eq("rx_data", e[M-1:0], d);
            check_eq("rx_perr", e[M+1], pe);
            check_eq("rx_ferr", e[M], fe);
        end
    endtask

    task automatic send_check(input int sel, input logic [M-1:0] d);
        int f;
        build_frame(d, par_of(sel), stop_of(sel));
        f = CPB * fr_len;
        rx_clear();
        @(negedge clk);
        check_eq("ready_idle", rdy[sel], 1);
        dv[sel]  = 1'b1;
        txb[sel] = d;
        @(posedge clk); #1;
        dv[sel]  = 1'b0;
        txb[sel] = M'($urandom);
        check_eq("active_start", tx_act[sel], 1);
        check_eq("ready_busy", rdy[sel], 0);
        for (int c = 0; c < f; c++) begin
            check_eq("tx_bit", tx_ser[sel], fr[c/CPB]);
            check_eq("sent_early", sent[sel], 0);
            @(posedge clk); #1;
        end
        check_eq("sent_pulse", sent[sel], 1);
        check_eq("ready_end", rdy[sel], 1);
        check_eq("active_end", tx_act[sel], 0);
        check_eq("tx_idle", tx_ser[sel], 1);
        @(posedge clk); #1;
        check_eq("sent_once", sent[sel], 0);
        repeat (12) @(posedge clk);
        rx_expect(sel, 1, d, 1'b0, 1'b0);
    endtask

    task automatic drive_bits(input int sel);
        for (int i = 0; i < fr_len; i++) begin
            drv[sel] = fr[i];
            repeat (CPB) @(negedge clk);
        end
    endtask

    initial begin
        logic [M-1:0] d;
        int t0, s0;
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            dv[i] = 1'b0; txb[i] = '0; loop_en[i] = 1'b1; drv[i] = 1'b1;
        end
        repeat (3) @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            check_eq("rst_tx_ser", tx_ser[i], 1);
            check_eq("rst_ready", rdy[i], 1);
            check_eq("rst_active", tx_act[i], 0);
            check_eq("rst_sent", sent[i], 0);
            check_eq("rst_rx_dv", rx_dv[i], 0);
            check_eq("rst_rx_b", rx_b[i], 0);
            check_eq("rst_perr", perr[i], 0);
            check_eq("rst_ferr", ferr[i], 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        send_check(0, 8'hEB);
        for (int i = 0; i < 6; i++) send_check(0, M'($urandom));

        // Held request: three frames back to back, then release.
        d = M'($urandom);
        txb[0] = d;
        rx_clear();
        @(negedge clk);
        for (int k = 0; k <= 125; k++) begin
            if (k > 0) @(negedge clk);
            check_eq("b2b_ready", rdy[0], (k % 40 == 0) || (k > 120));
            check_eq("b2b_sent", sent[0], (k == 41) || (k == 81) || (k == 121));
            if (k == 0)  dv[0] = 1'b1;
            if (k == 81) dv[0] = 1'b0;
        end
        repeat (12) @(negedge clk);
        rx_expect(0, 3, d, 1'b0, 1'b0);

        send_check(1, 8'h07);
        for (int i = 0; i < 4; i++) send_check(1, M'($urandom));

        // Inverted parity bit on the line of the parity-enabled instance.
        loop_en[1] = 1'b0;
        rx_clear();
        build_frame(8'h07, 1, 2);
        fr[1+M] = ~fr[1+M];
        @(negedge clk);
        drive_bits(1);
        repeat (12) @(negedge clk);
        rx_expect(1, 1, 8'h07, 1'b1, 1'b0);

        // Stop bit low followed by a held-low line, then recovery.
        loop_en[0] = 1'b0;
        rx_clear();
        d = M'($urandom);
        build_frame(d, 0, 1);
        fr[fr_len-1] = 1'b0;
        @(negedge clk);
        drive_bits(0);
        repeat (20) @(negedge clk);
        rx_expect(0, 1, d, 1'b0, 1'b1);
        drv[0] = 1'b1;
        repeat (8) @(negedge clk);
        check_eq("no_dv_after_break", rxq0.size(), 0);
        d = M'($urandom);
        build_frame(d, 0, 1);
        t0 = cyc;
        drive_bits(0);
        repeat (12) @(negedge clk);
        if (rxt0.size() > 0)
            check_eq("rx_latency", ((rxt0[0] - t0) >= 39) && ((rxt0[0] - t0) <= 41), 1);
        rx_expect(0, 1, d, 1'b0, 1'b0);

        // One-cycle low glitch, then a real frame five cycles later.
        drv[0] = 1'b0;
        @(negedge clk);
        drv[0] = 1'b1;
        repeat (4) @(negedge clk);
        d = M'($urandom);
        build_frame(d, 0, 1);
        drive_bits(0);
        repeat (12) @(negedge clk);
        rx_expect(0, 1, d, 1'b0, 1'b0);
        loop_en[0] = 1'b1;
        repeat (4) @(negedge clk);

        // Reset during data bit 3 of a transmitted frame.
        rx_clear();
        s0 = sent_cnt0;
        dv[0]  = 1'b1;
        txb[0] = M'($urandom);
        @(posedge clk); #1;
        dv[0] = 1'b0;
        repeat (17) @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_eq("mid_rst_tx_ser", tx_ser[0], 1);
        check_eq("mid_rst_active", tx_act[0], 0);
        check_eq("mid_rst_ready", rdy[0], 1);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        check_eq("mid_rst_no_sent", sent_cnt0 - s0, 0);
        check_eq("mid_rst_no_rx", rxq0.size(), 0);
        send_check(0, M'($urandom));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
